// File: rtl/enc_pkg.sv
// enc_pkg: shared sizing defaults and the round-robin first-set search
package enc_pkg;

    localparam int ENC_N_DEFAULT = 8;
    localparam int ENC_W_DEFAULT = 3;

    // Returns {found, index}: first set bit of vec[n-1:0] scanning from ptr upward with wrap; n is a power of two <= 32
    function automatic logic [5:0] rr_first(input logic [31:0] vec, input logic [4:0] ptr, input int n);
        logic       found;
        logic [4:0] idx;
        logic [4:0] j;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < 32; i++) begin
            j = 5'(ptr + 5'(i)) & 5'(n - 1);
            if (i < n && !found && vec[j]) begin
                found = 1'b1;
                idx   = j;
            end
        end
        return {found, idx};
    endfunction

endpackage

// File: rtl/decoder.sv
// decoder: 3-to-8 one-hot decoder with enable
module decoder (
    input  logic [2:0] S,
    input  logic       Enable,
    output logic [7:0] Y
);

    assign Y = Enable ? (8'b1 << S) : 8'b0;

endmodule

// File: rtl/rr_priority_encoder.sv
// rr_priority_encoder: round-robin priority encoder with registered index, valid/ready handshake and one-hot Grant.
// Define RR_ENC_FIXED_PRIO_EN to tie the search pointer to 0 (fixed lowest-index priority, no pointer register).
module rr_priority_encoder
    import enc_pkg::*;
#(
    parameter int N = ENC_N_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Enable,
    input  logic [N-1:0]         R,
    output logic [$clog2(N)-1:0] O,
    output logic                 Valid,
    input  logic                 Ready,
    output logic [N-1:0]         Grant
);

    localparam int W = $clog2(N);

    logic [W-1:0] O_q, O_d;
    logic         Valid_q, Valid_d;
    logic [W-1:0] ptr;
    logic         accept, free, load;
    logic [N-1:0] rm;
    logic [5:0]   sel;
    logic [W-1:0] idx;

    assign accept = Valid_q & Ready;
    assign free   = ~Valid_q | accept;
    // The granted requester is still high during its accept cycle, so its bit is masked out of the search
    assign rm     = R & ~(accept ? (N'(1) << O_q) : '0);
    assign sel    = rr_first(32'(rm), 5'(ptr), N);
    assign idx    = sel[W-1:0];
    assign load   = free & Enable & sel[5];

    if (W < 5) begin : g_unused
        logic unused_hi;
        assign unused_hi = |sel[4:W];
    end

    // Next output state: load a new index, or drop Valid on an accept with nothing to load
    always_comb begin
        O_d     = load ? idx : O_q;
        Valid_d = load | (Valid_q & ~accept);
    end

    // Output register
    always_ff @(posedge clk) begin
        if (rst) begin
            O_q     <= '0;
            Valid_q <= 1'b0;
        end else begin
            O_q     <= O_d;
            Valid_q <= Valid_d;
        end
    end

`ifdef RR_ENC_FIXED_PRIO_EN
    assign ptr = '0;
`else
    logic [W-1:0] ptr_q, ptr_d;

    // Pointer advances past the index just loaded
    always_comb begin
        ptr_d = load ? W'(idx + W'(1)) : ptr_q;
    end

    // Round-robin pointer register
    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

    assign ptr = ptr_q;
`endif

    if (N == 8) begin : g_dec
        decoder u_dec (
            .S      (O_q),
            .Enable (accept),
            .Y      (Grant)
        );
    end else begin : g_onehot
        assign Grant = accept ? (N'(1) << O_q) : '0;
    end

    assign O     = O_q;
    assign Valid = Valid_q;

endmodule

// File: tb/tb_rr_priority_encoder.sv
// tb_rr_priority_encoder: directed self-checking bench for rr_priority_encoder (N = 8)
module tb_rr_priority_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       Enable;
    logic [7:0] R;
    logic [2:0] O;
    logic       Valid;
    logic       Ready;
    logic [7:0] Grant;

    int n_asserts = 0;
    int n_fail    = 0;

    rr_priority_encoder #(.N(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .Enable (Enable),
        .R      (R),
        .O      (O),
        .Valid  (Valid),
        .Ready  (Ready),
        .Grant  (Grant)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; Enable = 1'b1; Ready = 1'b1; R = 8'hFF;
        tick();
        tick();
        chk("rst_valid", 32'(Valid), 0);
        chk("rst_o",     32'(O),     0);
        chk("rst_grant", 32'(Grant), 0);

        rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk($sformatf("rot_o_%0d", i),     32'(O),     32'(i % 8));
            chk($sformatf("rot_grant_%0d", i), 32'(Grant), 32'(8'b1 << (i % 8)));
        end

        Ready = 1'b0; R = 8'h20;
        tick();
        chk("hold_o",     32'(O),     0);
        chk("hold_valid", 32'(Valid), 1);
        chk("hold_grant", 32'(Grant), 0);
        Ready = 1'b1;
        tick();
        chk("wrap_pre_o", 32'(O), 5);
        R = 8'b0000_0101;
        tick();
        chk("wrap_o0", 32'(O), 0);
        tick();
        chk("wrap_o2", 32'(O), 2);

        R = 8'h10;
        tick();
        chk("bp_o", 32'(O), 4);
        Ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) R = 8'h01;
            tick();
            chk($sformatf("bp_o_%0d", i),     32'(O),     4);
            chk($sformatf("bp_valid_%0d", i), 32'(Valid), 1);
            chk($sformatf("bp_grant_%0d", i), 32'(Grant), 0);
        end
        Ready = 1'b1;
        #1;
        chk("bp_accept_grant", 32'(Grant), 32'h10);
        tick();
        chk("bp_next_o", 32'(O), 0);

        R = 8'h08;
        tick();
        chk("single_o",     32'(O),     3);
        chk("single_grant", 32'(Grant), 32'h08);
        tick();
        R = 8'h00;
        chk("single_drop_valid", 32'(Valid), 0);
        chk("single_drop_grant", 32'(Grant), 0);
        tick();
        chk("single_idle_valid", 32'(Valid), 0);
        chk("single_idle_grant", 32'(Grant), 0);

        Ready = 1'b0; R = 8'h08;
        tick();
        chk("en_load_o",     32'(O),     3);
        chk("en_load_valid", 32'(Valid), 1);
        Enable = 1'b0; R = 8'hFF;
        tick();
        chk("en_hold_o",     32'(O),     3);
        chk("en_hold_valid", 32'(Valid), 1);
        chk("en_hold_grant", 32'(Grant), 0);
        Ready = 1'b1;
        #1;
        chk("en_grant", 32'(Grant), 32'h08);
        tick();
        chk("en_drop_valid", 32'(Valid), 0);
        tick();
        chk("en_noreload_valid", 32'(Valid), 0);
        chk("en_noreload_grant", 32'(Grant), 0);
        Enable = 1'b1;
        tick();
        chk("en_resume_o", 32'(O), 4);

        Ready = 1'b0;
        tick();
        chk("mid_valid", 32'(Valid), 1);
        rst = 1'b1; Ready = 1'b1;
        tick();
        chk("mid_rst_valid", 32'(Valid), 0);
        chk("mid_rst_o",     32'(O),     0);
        chk("mid_rst_grant", 32'(Grant), 0);
        rst = 1'b0;
        tick();
        chk("post_rst_o",     32'(O),     0);
        chk("post_rst_grant", 32'(Grant), 32'h01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
